traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker that sits on the four 2-bit light outputs of the intersection controller and decodes them back into phase, direction and run length. It flags conflicting, illegal, out-of-sequence and mistimed light patterns. It also reports green-phase statistics to the supervisory logic. It never drives the lights.

## Interface
- GREEN_MIN, 10: minimum legal green run, in samples
- GREEN_MAX, 19: maximum legal green run, in samples (≤ 254)
- YELLOW_CYCLES, 3: exact legal yellow run, in samples
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- Light_north / Light_east / Light_south / Light_west  in  2 each  light code: 2'b00 red, 2'b01 yellow, 2'b10 green, 2'b11 illegal
- clr  in  1  synchronous clear of sticky error flags
- mon_phase  out  2  0 SYNC, 1 IDLE, 2 GREEN, 3 YELLOW
- mon_dir  out  2  active direction: 0 N, 1 E, 2 S, 3 W
- err_conflict / err_illegal / err_sequence / err_timing / err_rotation  out  1 each  sticky error flags
- err_pulse  out  1  one-cycle pulse on any new detection
- green_len_last  out  8  length of the last completed green run
- green_count  out  16  number of completed greens; wraps at 2^16

## Operation
- Classification is combinational each cycle:
  - active = directions with a non-red code
  - illegal = any code 2'b11
  - conflict = two or more active directions
- If illegal or conflict: set the matching flag(s), go to SYNC, skip all other checks that cycle.
- SYNC: wait for an all-red sample, then go to IDLE. No sequence or timing checks.
- IDLE:
  - all-red: stay
  - single green d: go to GREEN(d), run=1
  - single yellow: err_sequence, go to SYNC
- GREEN(d):
  - green d: run++ (saturates at 255)
  - yellow d: green_len_last=run, green_count++; err_timing if run<GREEN_MIN and not already flagged this run; go to YELLOW(d), run=1
  - all-red, or any other direction active: err_sequence, go to SYNC
- YELLOW(d):
  - yellow d: run++
  - all-red: go to IDLE
  - green e≠d: go to GREEN(e), run=1; err_rotation if e≠(d+1) mod 4
  - green d, or yellow e≠d: err_sequence, go to SYNC
  - Leaving yellow by either legal exit: err_timing if run≠YELLOW_CYCLES and not already flagged this run.
- Stuck-light detection: err_timing fires on the sample where a green run reaches GREEN_MAX+1 or a yellow run reaches YELLOW_CYCLES+1. It fires at most once per run; a per-run "flagged" bit suppresses the end-of-run check.
- All-red gaps are never timed.

## Timing
- Latency: every output reflects the input sample of the previous cycle. An error flag is visible one cycle after the offending input.
- err_pulse is high for exactly one cycle per detection cycle, even if several flags set in that cycle.
- Sticky flags clear only on rst or clr. If clr and a new detection coincide, the new detection wins and the flag ends set.
- Reset values: mon_phase=SYNC(0), mon_dir=0, all error flags 0, err_pulse 0, green_len_last 0, green_count 0, run 0.
- Reset mid-run discards the run with no error. The first run after reset is checked only after an all-red sample.

## Configuration
- TLM_ROTATION_CHECK_EN defined: the N→E→S→W rotation is enforced on yellow→green handoffs and err_rotation is live.
- Not defined: err_rotation is tied to 0, any yellow(d)→green(e≠d) handoff is legal, and no rotation logic is built.

## Structure
- Package tlm_pkg holds:
  - light-code constants (RED, YELLOW, GREEN, ILLEGAL)
  - direction enum (N, E, S, W)
  - phase enum (SYNC, IDLE, GREEN, YELLOW)
  - run-counter width (8)
- Sub-module tlm_light_decode (combinational): maps the four codes to green[3:0], yellow[3:0], an illegal bit, an all-red bit and an active-count.

## Test plan
- Legal sequence: reset, 2 all-red, N green ×10, N yellow ×3, E green ×19, E yellow ×3, all-red → no flags, green_count=2, green_len_last=19, mon_phase=IDLE.
- Conflict: during N green, drive E=2'b01 for one cycle → err_conflict=1 and err_pulse high 1 cycle; mon_phase=SYNC until the first all-red, then IDLE.
- Illegal code: Light_west=2'b11 → err_illegal=1 next cycle; clr pulse → flag returns to 0.
- Short green: N green ×8 then yellow → err_timing=1 one cycle after the yellow sample, green_len_last=8.
- Stuck green: N green held ×25 → err_timing rises one cycle after sample 20; err_pulse fires once; no second pulse at the later yellow.
- Rotation: N green ×10, N yellow ×3, then S green → err_rotation=1 with the macro defined; 0 without it; err_sequence=0 either way.

Source files
------------

// File: rtl/tlm_pkg.sv
// Shared types for the traffic light monitor.
// Light codes, direction/phase enums and run-counter width.
package tlm_pkg;

  localparam int RUN_W = 8;

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] GREEN   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    DIR_N, DIR_E, DIR_S, DIR_W
  } dir_t;

  typedef enum logic [1:0] {
    PH_SYNC, PH_IDLE, PH_GREEN, PH_YELLOW
  } phase_t;

  typedef struct packed {
    logic conflict;
    logic illegal;
    logic seq;
    logic timing;
  } err_t;

  // Valid only for one-hot input; callers guarantee that.
  function automatic dir_t onehot_dir(
    input logic [3:0] v
  );
    return dir_t'({v[3] | v[2], v[3] | v[1]});
  endfunction

endpackage

// File: rtl/tlm_light_decode.sv
// Combinational decode of the four light codes.
// Index 0..3 = N, E, S, W.
module tlm_light_decode
  import tlm_pkg::*;
(
  input  logic [1:0] north,
  input  logic [1:0] east,
  input  logic [1:0] south,
  input  logic [1:0] west,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       illegal,
  output logic       all_red,
  output logic [2:0] active_cnt
);

  logic [3:0][1:0] code;

  assign code = {west, south, east, north};

  always_comb begin
    green      = '0;
    yellow     = '0;
    illegal    = 1'b0;
    active_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      green[i]  = (code[i] == GREEN);
      yellow[i] = (code[i] == YELLOW);
      if (code[i] == ILLEGAL) illegal = 1'b1;
      if (code[i] != RED) active_cnt = active_cnt + 3'd1;
    end
  end

  assign all_red = (active_cnt == 3'd0);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the intersection light outputs.
// Define TLM_ROTATION_CHECK_EN to enforce N->E->S->W handoffs.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int GREEN_MIN     = 10,
  parameter int GREEN_MAX     = 19,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Light_north,
  input  logic [1:0]  Light_east,
  input  logic [1:0]  Light_south,
  input  logic [1:0]  Light_west,
  input  logic        clr,
  output logic [1:0]  mon_phase,
  output logic [1:0]  mon_dir,
  output logic        err_conflict,
  output logic        err_illegal,
  output logic        err_sequence,
  output logic        err_timing,
  output logic        err_rotation,
  output logic        err_pulse,
  output logic [7:0]  green_len_last,
  output logic [15:0] green_count
);

  localparam logic [RUN_W-1:0] G_MIN =
    RUN_W'(GREEN_MIN);
  localparam logic [RUN_W-1:0] G_STUCK =
    RUN_W'(GREEN_MAX + 1);
  localparam logic [RUN_W-1:0] Y_LEN =
    RUN_W'(YELLOW_CYCLES);
  localparam logic [RUN_W-1:0] Y_STUCK =
    RUN_W'(YELLOW_CYCLES + 1);

  logic [3:0] green;
  logic [3:0] yellow;
  logic       illegal;
  logic       all_red;
  logic [2:0] active_cnt;

  tlm_light_decode u_decode (
    .north      (Light_north),
    .east       (Light_east),
    .south      (Light_south),
    .west       (Light_west),
    .green      (green),
    .yellow     (yellow),
    .illegal    (illegal),
    .all_red    (all_red),
    .active_cnt (active_cnt)
  );

  phase_t           phase, phase_nx;
  dir_t             dir, dir_nx;
  logic [RUN_W-1:0] run, run_nx, run_inc;
  logic             flagged, flagged_nx;
  logic [7:0]       len_nx;
  logic [15:0]      cnt_nx;
  err_t             err, set;
  logic             rot_set;
  logic             y_bad;
  dir_t             gdir;

  assign run_inc = (run == '1) ? run : run + 1'b1;
  assign gdir    = onehot_dir(green);
  assign y_bad   = (run != Y_LEN) && !flagged;

  always_comb begin
    phase_nx   = phase;
    dir_nx     = dir;
    run_nx     = run;
    flagged_nx = flagged;
    len_nx     = green_len_last;
    cnt_nx     = green_count;
    set        = '0;
    rot_set    = 1'b0;
    if (illegal || active_cnt > 3'd1) begin
      set.illegal  = illegal;
      set.conflict = (active_cnt > 3'd1);
      phase_nx     = PH_SYNC;
      run_nx       = '0;
      flagged_nx   = 1'b0;
    end else begin
      unique case (phase)
        PH_SYNC: begin
          if (all_red) phase_nx = PH_IDLE;
        end
        PH_IDLE: begin
          if (|green) begin
            phase_nx   = PH_GREEN;
            dir_nx     = gdir;
            run_nx     = 1;
            flagged_nx = 1'b0;
          end else if (|yellow) begin
            set.seq  = 1'b1;
            phase_nx = PH_SYNC;
          end
        end
        PH_GREEN: begin
          if (green[dir]) begin
            run_nx = run_inc;
            if (run_inc == G_STUCK && !flagged) begin
              set.timing = 1'b1;
              flagged_nx = 1'b1;
            end
          end else if (yellow[dir]) begin
            len_nx     = run;
            cnt_nx     = green_count + 16'd1;
            set.timing = (run < G_MIN) && !flagged;
            phase_nx   = PH_YELLOW;
            run_nx     = 1;
            flagged_nx = 1'b0;
          end else begin
            set.seq  = 1'b1;
            phase_nx = PH_SYNC;
            run_nx   = '0;
          end
        end
        PH_YELLOW: begin
          if (yellow[dir]) begin
            run_nx = run_inc;
            if (run_inc == Y_STUCK && !flagged) begin
              set.timing = 1'b1;
              flagged_nx = 1'b1;
            end
          end else if (all_red) begin
            set.timing = y_bad;
            phase_nx   = PH_IDLE;
          end else if (|green && !green[dir]) begin
            set.timing = y_bad;
`ifdef TLM_ROTATION_CHECK_EN
            rot_set = (gdir != dir_t'(dir + 2'd1));
`endif
            phase_nx   = PH_GREEN;
            dir_nx     = gdir;
            run_nx     = 1;
            flagged_nx = 1'b0;
          end else begin
            set.seq  = 1'b1;
            phase_nx = PH_SYNC;
            run_nx   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase          <= PH_SYNC;
      dir            <= DIR_N;
      run            <= '0;
      flagged        <= 1'b0;
      err            <= '0;
      err_pulse      <= 1'b0;
      green_len_last <= '0;
      green_count    <= '0;
    end else begin
      phase          <= phase_nx;
      dir            <= dir_nx;
      run            <= run_nx;
      flagged        <= flagged_nx;
      // A new detection overrides a coincident clear.
      err            <= (clr ? '0 : err) | set;
      err_pulse      <= (|set) | rot_set;
      green_len_last <= len_nx;
      green_count    <= cnt_nx;
    end
  end

`ifdef TLM_ROTATION_CHECK_EN
  logic rot_err;

  always_ff @(posedge clk) begin
    if (rst) rot_err <= 1'b0;
    else     rot_err <= (rot_err & ~clr) | rot_set;
  end

  assign err_rotation = rot_err;
`else
  assign err_rotation = 1'b0;
`endif

  assign mon_phase    = phase;
  assign mon_dir      = dir;
  assign err_conflict = err.conflict;
  assign err_illegal  = err.illegal;
  assign err_sequence = err.seq;
  assign err_timing   = err.timing;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: table vectors,
// hand sequences and random traffic against a reference model.
module tb_traffic_light_monitor;

  localparam int GMIN = 10;
  localparam int GMAX = 19;
  localparam int YC   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [1:0]  ln = 2'b00, le = 2'b00;
  logic [1:0]  ls = 2'b00, lw = 2'b00;
  logic [1:0]  mon_phase, mon_dir;
  logic        e_c, e_i, e_s, e_t, e_r, pulse;
  logic [7:0]  len_last;
  logic [15:0] gcount;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREEN_MIN     (GMIN),
    .GREEN_MAX     (GMAX),
    .YELLOW_CYCLES (YC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Light_north    (ln),
    .Light_east     (le),
    .Light_south    (ls),
    .Light_west     (lw),
    .clr            (clr),
    .mon_phase      (mon_phase),
    .mon_dir        (mon_dir),
    .err_conflict   (e_c),
    .err_illegal    (e_i),
    .err_sequence   (e_s),
    .err_timing     (e_t),
    .err_rotation   (e_r),
    .err_pulse      (pulse),
    .green_len_last (len_last),
    .green_count    (gcount)
  );

  int vectors = 0;
  int miscompares = 0;
  bit rot_en;

  // Reference model state (0 SYNC, 1 IDLE, 2 GREEN, 3 YELLOW).
  int       m_phase, m_dir, m_run, m_len, m_cnt;
  bit       m_flag, m_pulse;
  bit [4:0] m_err;

  function automatic logic [36:0] got();
    return {mon_phase, mon_dir, e_c, e_i, e_s, e_t, e_r,
            pulse, len_last, gcount};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_dir = 0; m_run = 0; m_len = 0;
    m_cnt = 0; m_flag = 0; m_pulse = 0; m_err = 0;
  endtask

  // Lights packed {N,E,S,W}; direction i uses bits [7-2i -: 2].
  task automatic model_step(input logic [7:0] l, input bit c);
    int nact, g, y, code;
    bit ill;
    bit [4:0] s;
    nact = 0; g = -1; y = -1; ill = 0; s = 0;
    for (int i = 0; i < 4; i++) begin
      code = int'(l[7-2*i -: 2]);
      if (code != 0) nact++;
      if (code == 3) ill = 1;
      if (code == 2) g = i;
      if (code == 1) y = i;
    end
    if (ill || nact > 1) begin
      s[4] = (nact > 1);
      s[3] = ill;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (nact == 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (g >= 0) begin
        m_phase = 2; m_dir = g; m_run = 1; m_flag = 0;
      end else if (y >= 0) begin
        s[2] = 1; m_phase = 0;
      end
    end else if (m_phase == 2) begin
      if (g == m_dir) begin
        m_run = (m_run < 255) ? m_run + 1 : 255;
        if (m_run == GMAX + 1 && !m_flag) begin
          s[1] = 1; m_flag = 1;
        end
      end else if (y == m_dir) begin
        m_len = m_run;
        m_cnt = (m_cnt + 1) % 65536;
        if (m_run < GMIN && !m_flag) s[1] = 1;
        m_phase = 3; m_run = 1; m_flag = 0;
      end else begin
        s[2] = 1; m_phase = 0;
      end
    end else begin
      if (y == m_dir) begin
        m_run = (m_run < 255) ? m_run + 1 : 255;
        if (m_run == YC + 1 && !m_flag) begin
          s[1] = 1; m_flag = 1;
        end
      end else if (nact == 0) begin
        if (m_run != YC && !m_flag) s[1] = 1;
        m_phase = 1;
      end else if (g >= 0 && g != m_dir) begin
        if (m_run != YC && !m_flag) s[1] = 1;
        if (rot_en && g != (m_dir + 1) % 4) s[0] = 1;
        m_phase = 2; m_dir = g; m_run = 1; m_flag = 0;
      end else begin
        s[2] = 1; m_phase = 0;
      end
    end
    m_err   = (c ? 5'b0 : m_err) | s;
    m_pulse = |s;
  endtask

  function automatic logic [36:0] model_out();
    return {2'(m_phase), 2'(m_dir), m_err, m_pulse,
            8'(m_len), 16'(m_cnt)};
  endfunction

  task automatic cycle(input logic [7:0] l, input bit c);
    @(negedge clk);
    rst = 1'b0;
    clr = c;
    {ln, le, ls, lw} = l;
    @(posedge clk);
    #1;
    model_step(l, c);
    vectors++;
    if (got() !== model_out()) begin
      miscompares++;
      $display("FAIL model t=%0t lights=%h clr=%0d got=%h exp=%h",
               $time, l, c, got(), model_out());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr = 1'b0;
    {ln, le, ls, lw} = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (got() !== 37'd0) begin
      miscompares++;
      $display("FAIL reset got=%h exp=%h", got(), 37'd0);
    end
  endtask

  typedef struct {
    logic [7:0]  l;
    bit          c;
    int          reps;
    logic [1:0]  ph;
    logic [1:0]  dir;
    logic [4:0]  err;
    bit          pulse;
    logic [7:0]  len;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] l, input bit c,
                     input int reps, input logic [1:0] ph,
                     input logic [1:0] d, input logic [4:0] e,
                     input bit p, input logic [7:0] len,
                     input logic [15:0] cnt);
    vec_t v;
    v = '{l, c, reps, ph, d, e, p, len, cnt};
    tbl.push_back(v);
  endtask

  logic [36:0] want;
  logic [7:0]  lights;
  int          d, glen, ylen, gap, k;
  bit          r;

  initial begin
`ifdef TLM_ROTATION_CHECK_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    r = rot_en;

    // legal sequence
    add(8'h00, 0,  2, 1, 0, 5'b00000, 0, 0,  0);
    add(8'h80, 0, 10, 2, 0, 5'b00000, 0, 0,  0);
    add(8'h40, 0,  3, 3, 0, 5'b00000, 0, 10, 1);
    add(8'h20, 0, 19, 2, 1, 5'b00000, 0, 10, 1);
    add(8'h10, 0,  3, 3, 1, 5'b00000, 0, 19, 2);
    add(8'h00, 0,  1, 1, 1, 5'b00000, 0, 19, 2);
    // conflict
    add(8'h80, 0,  3, 2, 0, 5'b00000, 0, 19, 2);
    add(8'h90, 0,  1, 0, 0, 5'b10000, 1, 19, 2);
    add(8'h80, 0,  2, 0, 0, 5'b10000, 0, 19, 2);
    add(8'h00, 0,  1, 1, 0, 5'b10000, 0, 19, 2);
    // illegal then clear
    add(8'h03, 0,  1, 0, 0, 5'b11000, 1, 19, 2);
    add(8'h00, 1,  1, 1, 0, 5'b00000, 0, 19, 2);
    // short green
    add(8'h80, 0,  8, 2, 0, 5'b00000, 0, 19, 2);
    add(8'h40, 0,  1, 3, 0, 5'b00010, 1, 8,  3);
    add(8'h40, 0,  2, 3, 0, 5'b00010, 0, 8,  3);
    add(8'h00, 1,  1, 1, 0, 5'b00000, 0, 8,  3);
    // stuck green
    add(8'h80, 0, 19, 2, 0, 5'b00000, 0, 8,  3);
    add(8'h80, 0,  1, 2, 0, 5'b00010, 1, 8,  3);
    add(8'h80, 0,  5, 2, 0, 5'b00010, 0, 8,  3);
    add(8'h40, 0,  1, 3, 0, 5'b00010, 0, 25, 4);
    add(8'h40, 0,  2, 3, 0, 5'b00010, 0, 25, 4);
    add(8'h00, 1,  1, 1, 0, 5'b00000, 0, 25, 4);
    // rotation N -> S
    add(8'h80, 0, 10, 2, 0, 5'b00000, 0, 25, 4);
    add(8'h40, 0,  3, 3, 0, 5'b00000, 0, 10, 5);
    add(8'h08, 0,  1, 2, 2, {4'b0, r}, r, 10, 5);
    add(8'h08, 0,  9, 2, 2, {4'b0, r}, 0, 10, 5);
    add(8'h04, 0,  3, 3, 2, {4'b0, r}, 0, 10, 6);
    add(8'h00, 0,  1, 1, 2, {4'b0, r}, 0, 10, 6);
    // yellow from idle, clear coinciding with detection
    add(8'h40, 1,  1, 0, 2, 5'b00100, 1, 10, 6);
    add(8'h00, 0,  1, 1, 2, 5'b00100, 0, 10, 6);
    add(8'h03, 1,  1, 0, 2, 5'b01000, 1, 10, 6);
    add(8'h00, 1,  1, 1, 2, 5'b00000, 0, 10, 6);
    // stuck yellow, no second flag at exit
    add(8'h80, 0, 10, 2, 0, 5'b00000, 0, 10, 6);
    add(8'h40, 0,  4, 3, 0, 5'b00010, 1, 10, 7);
    add(8'h40, 0,  1, 3, 0, 5'b00010, 0, 10, 7);
    add(8'h00, 0,  1, 1, 0, 5'b00010, 0, 10, 7);

    do_reset();
    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].reps; j++)
        cycle(tbl[i].l, tbl[i].c);
      want = {tbl[i].ph, tbl[i].dir, tbl[i].err,
              tbl[i].pulse, tbl[i].len, tbl[i].cnt};
      vectors++;
      if (got() !== want) begin
        miscompares++;
        $display("FAIL tbl[%0d] got=%h exp=%h", i, got(), want);
      end
    end

    // reset mid-green: no error, SYNC until an all-red sample
    cycle(8'h80, 0);
    do_reset();
    for (int j = 0; j < 3; j++) cycle(8'h80, 0);
    vectors++;
    if (mon_phase !== 2'd0 || {e_c, e_i, e_s, e_t, e_r} !== 5'd0)
    begin
      miscompares++;
      $display("FAIL post_reset phase=%0d err=%b exp 0/00000",
               mon_phase, {e_c, e_i, e_s, e_t, e_r});
    end
    cycle(8'h00, 0);
    vectors++;
    if (mon_phase !== 2'd1) begin
      miscompares++;
      $display("FAIL post_reset_idle phase=%0d exp 1", mon_phase);
    end

    // random traffic
    d = 0;
    for (int seg = 0; seg < 150; seg++) begin
      k = $urandom_range(0, 39);
      if (k == 0) begin
        do_reset();
      end else if (k < 4) begin
        lights = 8'($urandom);
        cycle(lights, $urandom_range(0, 3) == 0);
      end else begin
        d = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3)
                                        : (d + 1) % 4;
        glen = $urandom_range(GMIN - 2, GMAX + 3);
        ylen = $urandom_range(YC - 1, YC + 2);
        gap  = $urandom_range(0, 2);
        lights = 8'h80 >> (2 * d);
        for (int j = 0; j < glen; j++)
          cycle(lights, $urandom_range(0, 30) == 0);
        lights = 8'h40 >> (2 * d);
        for (int j = 0; j < ylen; j++)
          cycle(lights, $urandom_range(0, 30) == 0);
        for (int j = 0; j < gap; j++)
          cycle(8'h00, $urandom_range(0, 10) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
